// File: rtl/muldiv_sequencer_if.sv
// Handshake and result bundle between the EX/ID pipeline logic and the HI/LO
// multiply/divide sequencer.
interface muldiv_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              hilo_read;
  logic              hi_we;
  logic              lo_we;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              stall;
  logic              done;
  logic              div_by_zero;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, hilo_read, hi_we, lo_we, wdata,
    input  busy, stall, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, hilo_read, hi_we, lo_we, wdata,
    output busy, stall, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO multiply/divide unit: 32-step shift-add multiply and restoring
// divide on operand magnitudes, sign-corrected on commit; stalls the pipeline while busy.
module muldiv_sequencer #(
  parameter int DATA_W     = 32,
  parameter int ITER_CNT_W = 6
) (
  input  logic clk,
  input  logic reset,
  muldiv_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  localparam logic [ITER_CNT_W-1:0] LAST_ITER = ITER_CNT_W'(DATA_W - 1);

  state_t                  state, state_nxt;
  logic [1:0]              op_q;
  logic [DATA_W-1:0]       a_q, b_q;
  logic [DATA_W-1:0]       opnd;
  logic [DATA_W-1:0]       acc_hi, acc_lo;
  logic [ITER_CNT_W-1:0]   cnt;
  logic                    neg_res, neg_rem, dbz;
  logic [DATA_W-1:0]       hi_r, lo_r;
  logic                    done_r, dbz_r;

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] cond_neg2(input logic [2*DATA_W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  logic              is_div, is_signed, neg_a, neg_b;
  logic signed [DATA_W-1:0] a_s, b_s;
  logic [DATA_W-1:0] a_mag, b_mag;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign a_s       = a_q;
  assign b_s       = b_q;
  assign neg_a     = is_signed && (a_s < 0);
  assign neg_b     = is_signed && (b_s < 0);
  assign a_mag     = cond_neg(a_q, neg_a);
  assign b_mag     = cond_neg(b_q, neg_b);

  // One iteration step: multiply adds the multiplicand when the low bit is set
  // and shifts right; divide shifts the next dividend bit into the remainder.
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   div_shift;
  logic [DATA_W-1:0] div_diff;
  logic              div_ge;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign div_shift = {acc_hi, acc_lo[DATA_W-1]};
  assign div_ge    = div_shift >= {1'b0, opnd};
  assign div_diff  = div_shift[DATA_W-1:0] - opnd;

  logic [2*DATA_W-1:0] product;
  assign product = cond_neg2({acc_hi, acc_lo}, neg_res);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.start) state_nxt = PREP;
      PREP: state_nxt = (is_div && b_q == '0) ? FIX : ITER;
      ITER: if (cnt == LAST_ITER) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      opnd    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dbz     <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
      done_r  <= 1'b0;
      dbz_r   <= 1'b0;
    end else begin
      done_r <= (state == FIX);
      dbz_r  <= (state == FIX) && dbz;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            op_q <= bus.op;
            a_q  <= bus.rs_val;
            b_q  <= bus.rt_val;
          end else begin
            if (bus.hi_we) hi_r <= bus.wdata;
            if (bus.lo_we) lo_r <= bus.wdata;
          end
        end
        PREP: begin
          neg_res <= neg_a ^ neg_b;
          neg_rem <= is_div && neg_a;
          dbz     <= is_div && (b_q == '0);
          acc_hi  <= '0;
          acc_lo  <= is_div ? a_mag : b_mag;
          opnd    <= is_div ? b_mag : a_mag;
          cnt     <= '0;
        end
        ITER: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            acc_hi <= div_ge ? div_diff : div_shift[DATA_W-1:0];
            acc_lo <= {acc_lo[DATA_W-2:0], div_ge};
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[DATA_W-1:1]};
          end
        end
        FIX: begin
          if (dbz) begin
            hi_r <= a_q;
            lo_r <= '1;
          end else if (is_div) begin
            hi_r <= cond_neg(acc_hi, neg_rem);
            lo_r <= cond_neg(acc_lo, neg_res);
          end else begin
            {hi_r, lo_r} <= product;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.stall       = bus.busy && (bus.start || bus.hilo_read || bus.hi_we || bus.lo_we);
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for the HI/LO multiply/divide sequencer.
module tb_muldiv_sequencer;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  logic clk = 1'b0;
  logic reset;
  int   n_vec  = 0;
  int   n_miss = 0;

  muldiv_sequencer_if #(.DATA_W(32)) bus ();

  muldiv_sequencer #(.DATA_W(32), .ITER_CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Waits from the negedge after the start edge until done is seen; edges counts
  // the clock edges after the start edge, capped at 100.
  task automatic wait_done(output int edges, output logic dz);
    edges = 0;
    while (!bus.done && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    dz = bus.div_by_zero;
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int edges, output logic dz);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = o;
    bus.rs_val = a;
    bus.rt_val = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(edges, dz);
  endtask

  int   edges;
  logic dz;
  int   bad;
  int   cyc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.op        = 2'b00;
    bus.rs_val    = '0;
    bus.rt_val    = '0;
    bus.hilo_read = 1'b0;
    bus.hi_we     = 1'b0;
    bus.lo_we     = 1'b0;
    bus.wdata     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_hi",    bus.hi, 0);
    check_val("rst_lo",    bus.lo, 0);
    check_val("rst_busy",  bus.busy, 0);
    check_val("rst_done",  bus.done, 0);
    check_val("rst_stall", bus.stall, 0);
    reset = 1'b0;

    // Largest unsigned product
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, edges, dz);
    check_val("multu_lat",  edges, 34);
    check_val("multu_hi",   bus.hi, 32'hFFFF_FFFE);
    check_val("multu_lo",   bus.lo, 32'h0000_0001);
    check_val("multu_busy", bus.busy, 0);
    check_val("multu_dz",   dz, 0);
    @(negedge clk);
    check_val("done_pulse", bus.done, 0);

    do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, edges, dz);
    check_val("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check_val("mult_lo", bus.lo, 32'hFFFF_FFEB);

    do_op(OP_DIVU, 32'd100, 32'd7, edges, dz);
    check_val("divu_lat", edges, 34);
    check_val("divu_lo",  bus.lo, 32'd14);
    check_val("divu_hi",  bus.hi, 32'd2);

    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, edges, dz);
    check_val("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
    check_val("div_neg_hi", bus.hi, 32'hFFFF_FFFF);

    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, edges, dz);
    check_val("div_ovf_lo", bus.lo, 32'h8000_0000);
    check_val("div_ovf_hi", bus.hi, 32'h0000_0000);

    do_op(OP_DIV, 32'd5, 32'd0, edges, dz);
    check_val("dbz_lat",  edges, 2);
    check_val("dbz_flag", dz, 1);
    check_val("dbz_done", bus.done, 1);
    check_val("dbz_hi",   bus.hi, 32'd5);
    check_val("dbz_lo",   bus.lo, 32'hFFFF_FFFF);
    @(negedge clk);
    check_val("dbz_pulse", bus.div_by_zero, 0);

    // MTHI / MTLO while idle
    bus.hi_we = 1'b1;
    bus.wdata = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    bus.hi_we = 1'b0;
    check_val("mthi", bus.hi, 32'h1234);
    bus.lo_we = 1'b1;
    bus.wdata = 32'h5678;
    @(posedge clk);
    @(negedge clk);
    bus.lo_we = 1'b0;
    check_val("mtlo", bus.lo, 32'h5678);

    // Second op and MFHI presented while busy
    bus.start  = 1'b1;
    bus.op     = OP_MULTU;
    bus.rs_val = 32'd2;
    bus.rt_val = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.op        = OP_DIVU;
    bus.rs_val    = 32'd100;
    bus.rt_val    = 32'd0;
    bus.hilo_read = 1'b1;
    bad = 0;
    cyc = 0;
    while (!bus.done && cyc < 100) begin
      if (!bus.stall) bad++;
      if (cyc == 1) check_val("hi_stable", bus.hi, 32'h1234);
      if (cyc == 3) bus.start = 1'b0;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check_val("stall_busy",  bad, 0);
    check_val("stall_lat",   cyc, 34);
    check_val("stall_done",  bus.stall, 0);
    check_val("busy_mul_hi", bus.hi, 0);
    check_val("busy_mul_lo", bus.lo, 6);
    bus.hilo_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("no_2nd_op", bus.busy, 0);

    // MTHI presented together with start is dropped
    bus.hi_we  = 1'b1;
    bus.wdata  = 32'hBEEF;
    bus.start  = 1'b1;
    bus.op     = OP_MULTU;
    bus.rs_val = 32'd3;
    bus.rt_val = 32'd4;
    @(posedge clk);
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.start = 1'b0;
    check_val("mthi_dropped", bus.hi, 0);
    wait_done(edges, dz);
    check_val("mthi_op_lo", bus.lo, 12);

    // Asynchronous reset in the middle of a MULT
    bus.hi_we = 1'b1;
    bus.wdata = 32'hAAAA;
    @(posedge clk);
    @(negedge clk);
    bus.hi_we  = 1'b0;
    bus.start  = 1'b1;
    bus.op     = OP_MULT;
    bus.rs_val = 32'hFFFF_FFFD;
    bus.rt_val = 32'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    bus.hilo_read = 1'b1;
    #1;
    check_val("mid_stall", bus.stall, 1);
    check_val("mid_hi",    bus.hi, 32'hAAAA);
    #1 reset = 1'b1;
    #1;
    check_val("arst_busy",  bus.busy, 0);
    check_val("arst_stall", bus.stall, 0);
    check_val("arst_hi",    bus.hi, 0);
    check_val("arst_lo",    bus.lo, 0);
    @(negedge clk);
    reset         = 1'b0;
    bus.hilo_read = 1'b0;

    do_op(OP_MULTU, 32'd3, 32'd4, edges, dz);
    check_val("post_rst_lat", edges, 34);
    check_val("post_rst_lo",  bus.lo, 12);
    check_val("post_rst_hi",  bus.hi, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
